// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold limit, active-low one-hot grant
module rr_arbiter8 #(
  parameter int HOLD_MAX = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       En,
  input  logic [7:0] R,
  output logic [7:0] Gn,
  output logic [2:0] Wg,
  output logic       Valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [2:0] p_q, p_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] wg_q, wg_d;
  logic [7:0] gn_q, gn_d;
  logic [2:0] sel_idx;
  logic [7:0] others;
  logic       grant;

  function automatic logic [2:0] first_from(input logic [7:0] req, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    first_from = start;
    found      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && req[idx]) begin
        first_from = idx;
        found      = 1'b1;
      end
    end
  endfunction

  // While BUSY the pointer already sits at owner+1, so one search serves both
  // fresh grants and handovers; the old owner is reached last.
  assign sel_idx = first_from(R, p_q);
  assign others  = R & ~(8'b1 << wg_q);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    wg_d    = wg_q;
    grant   = 1'b0;
    if (!En) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      wg_d    = 3'd0;
    end else if (state_q == IDLE) begin
      if (R != 8'h00) grant = 1'b1;
    end else if (R[wg_q]) begin
      if (cnt_q < HOLD_CNT) cnt_d = cnt_q + 4'd1;
      else if (others != 8'h00) grant = 1'b1;
    end else if (R != 8'h00) begin
      grant = 1'b1;
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      wg_d    = 3'd0;
    end
    if (grant) begin
      state_d = BUSY;
      wg_d    = sel_idx;
      p_d     = sel_idx + 3'd1;
      cnt_d   = 4'd1;
    end
    gn_d = (state_d == BUSY) ? ~(8'b1 << wg_d) : 8'hFF;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      p_q     <= 3'd0;
      cnt_q   <= 4'd0;
      wg_q    <= 3'd0;
      gn_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      wg_q    <= wg_d;
      gn_q    <= gn_d;
    end
  end

  assign Gn    = gn_q;
  assign Wg    = wg_q;
  assign Valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       En = 1'b0;
  logic [7:0] R = 8'h00;
  logic [7:0] Gn;
  logic [2:0] Wg;
  logic       Valid;

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_p = 0;
  int m_cnt = 0;

  rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .Clock(Clock), .Resetn(Resetn), .En(En), .R(R),
    .Gn(Gn), .Wg(Wg), .Valid(Valid)
  );

  always #5 Clock = ~Clock;

  function automatic int first_from(input logic [7:0] r, input int s);
    for (int k = 0; k < 8; k++)
      if (r[(s + k) % 8]) return (s + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_gn();
    logic [7:0] g;
    g = 8'hFF;
    if (m_owner >= 0) g[m_owner] = 1'b0;
    return g;
  endfunction

  function automatic logic [2:0] exp_wg();
    return (m_owner >= 0) ? 3'(m_owner) : 3'd0;
  endfunction

  task automatic model_grant(input int i);
    m_owner = i;
    m_p     = (i + 1) % 8;
    m_cnt   = 1;
  endtask

  task automatic model_step(input logic rstn, input logic en, input logic [7:0] r);
    logic [7:0] oth;
    if (!rstn) begin
      m_owner = -1; m_p = 0; m_cnt = 0;
    end else if (!en) begin
      m_owner = -1; m_cnt = 0;
    end else if (m_owner < 0) begin
      if (r != 0) model_grant(first_from(r, m_p));
    end else if (r[m_owner]) begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (m_cnt < HOLD) m_cnt++;
      else if (oth != 0) model_grant(first_from(r, (m_owner + 1) % 8));
    end else if (r != 0) begin
      model_grant(first_from(r, (m_owner + 1) % 8));
    end else begin
      m_owner = -1; m_cnt = 0;
    end
  endtask

  task automatic drive(input logic rstn, input logic en, input logic [7:0] r);
    @(negedge Clock);
    Resetn = rstn; En = en; R = r;
    @(posedge Clock);
    model_step(rstn, en, r);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 8'hFF);
      checks++;
      if (Gn !== 8'hFF || Wg !== 3'd0 || Valid !== 1'b0) begin
        errors++;
        $display("FAIL reset: Gn=%h Wg=%0d Valid=%b required Gn=ff Wg=0 Valid=0", Gn, Wg, Valid);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 8'h04);
      checks++;
      if (Valid !== 1'b1 || Wg !== 3'd2 || Gn !== 8'hFB) begin
        errors++;
        $display("FAIL single c%0d: Gn=%h Wg=%0d Valid=%b required Gn=fb Wg=2 Valid=1", c, Gn, Wg, Valid);
      end
    end
  endtask

  task automatic test_rotation();
    int exp_o;
    logic [7:0] eg;
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 36; c++) begin
      drive(1'b1, 1'b1, 8'hFF);
      exp_o = (c / HOLD) % 8;
      eg = 8'hFF;
      eg[exp_o] = 1'b0;
      checks++;
      if (Valid !== 1'b1 || Wg !== 3'(exp_o) || Gn !== eg) begin
        errors++;
        $display("FAIL rotation c%0d: Gn=%h Wg=%0d Valid=%b required Gn=%h Wg=%0d Valid=1", c, Gn, Wg, Valid, eg, exp_o);
      end
    end
  endtask

  task automatic test_handover();
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h20);
    drive(1'b1, 1'b1, 8'h02);
    checks++;
    if (Valid !== 1'b1 || Wg !== 3'd1 || Gn !== 8'hFD) begin
      errors++;
      $display("FAIL handover: Gn=%h Wg=%0d Valid=%b required Gn=fd Wg=1 Valid=1", Gn, Wg, Valid);
    end
    // owner 1 drops with 0,2,3 pending: search from 2 picks 2
    drive(1'b1, 1'b1, 8'h0D);
    checks++;
    if (Valid !== 1'b1 || Wg !== 3'd2) begin
      errors++;
      $display("FAIL handover_ptr: Wg=%0d Valid=%b required Wg=2 Valid=1", Wg, Valid);
    end
    drive(1'b1, 1'b1, 8'h00);
    checks++;
    if (Valid !== 1'b0 || Gn !== 8'hFF || Wg !== 3'd0) begin
      errors++;
      $display("FAIL release: Gn=%h Wg=%0d Valid=%b required Gn=ff Wg=0 Valid=0", Gn, Wg, Valid);
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 8'h08);
      checks++;
      if (Valid !== 1'b1 || Wg !== 3'd3 || Gn !== 8'hF7) begin
        errors++;
        $display("FAIL saturate c%0d: Gn=%h Wg=%0d Valid=%b required Gn=f7 Wg=3 Valid=1", c, Gn, Wg, Valid);
      end
    end
    drive(1'b1, 1'b1, 8'h09);
    checks++;
    if (Valid !== 1'b1 || Wg !== 3'd0) begin
      errors++;
      $display("FAIL saturate_yield: Wg=%0d Valid=%b required Wg=0 Valid=1", Wg, Valid);
    end
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h40);
    drive(1'b1, 1'b0, 8'h40);
    checks++;
    if (Valid !== 1'b0 || Gn !== 8'hFF || Wg !== 3'd0) begin
      errors++;
      $display("FAIL enable_off: Gn=%h Wg=%0d Valid=%b required Gn=ff Wg=0 Valid=0", Gn, Wg, Valid);
    end
    drive(1'b1, 1'b1, 8'hC1);
    checks++;
    if (Valid !== 1'b1 || Wg !== 3'd7 || Gn !== 8'h7F) begin
      errors++;
      $display("FAIL enable_ptr: Gn=%h Wg=%0d Valid=%b required Gn=7f Wg=7 Valid=1", Gn, Wg, Valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 6; c++) drive(1'b1, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'hFF);
    checks++;
    if (Valid !== 1'b0 || Gn !== 8'hFF || Wg !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: Gn=%h Wg=%0d Valid=%b required Gn=ff Wg=0 Valid=0", Gn, Wg, Valid);
    end
    drive(1'b1, 1'b1, 8'hFF);
    checks++;
    if (Valid !== 1'b1 || Wg !== 3'd0 || Gn !== 8'hFE) begin
      errors++;
      $display("FAIL reset_first: Gn=%h Wg=%0d Valid=%b required Gn=fe Wg=0 Valid=1", Gn, Wg, Valid);
    end
  endtask

  task automatic test_random();
    logic       rs, en;
    logic [7:0] r;
    int         zeros;
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 600; c++) begin
      rs = ($urandom_range(0, 99) != 0);
      en = ($urandom_range(0, 19) != 0);
      r  = 8'($urandom) & 8'($urandom);
      drive(rs, en, r);
      checks++;
      if (Gn !== exp_gn() || Wg !== exp_wg() || Valid !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL random c%0d: Gn=%h Wg=%0d Valid=%b required Gn=%h Wg=%0d Valid=%b",
                 c, Gn, Wg, Valid, exp_gn(), exp_wg(), m_owner >= 0);
      end
      zeros = 0;
      for (int i = 0; i < 8; i++) if (Gn[i] === 1'b0) zeros++;
      checks++;
      if (zeros > 1 || (Valid === 1'b1 && Gn[Wg] !== 1'b0)) begin
        errors++;
        $display("FAIL invariant c%0d: Gn=%h Wg=%0d Valid=%b required one-hot-low consistent with Wg", c, Gn, Wg, Valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_handover();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum consecutive grant cycles for one owner while another requester is pending (legal range 1..15).
REQ-002 Port: Clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: Resetn  input  1  reset, synchronous and active-low, sampled on the rising edge of Clock.
REQ-004 Port: En  input  1  arbiter enable; 0 releases any grant and blocks new grants.
REQ-005 Port: R  input  8  request vector; R[i] = 1 means requester i wants the shared resource.
REQ-006 Port: Gn  output  8  active-low one-hot grant, decoder style; Gn[i] = 0 means requester i owns the resource.
REQ-007 Port: Wg  output  3  binary index of the current owner.
REQ-008 Port: Valid  output  1  1 while a grant is active.

Function
REQ-009 All outputs SHALL be registered, with no combinational path from R or En to any output.
REQ-010 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner = Wg).
REQ-011 Internal state SHALL comprise a round-robin pointer P (3 bits) and a hold counter Cnt (4 bits).
REQ-012 Selection: search the pending requests starting at index P, ascending with wrap 7->0; the first set R[i] wins.
REQ-013 On every new grant to index i: P <= (i+1) mod 8 and Cnt <= 1.
REQ-014 IDLE, En=1, R != 0 at an edge: go to BUSY with the selected owner; grant latency is exactly 1 edge.
REQ-015 IDLE, R == 0 or En=0: remain in IDLE.
REQ-016 BUSY, R[owner]=1, Cnt < HOLD_MAX: keep the owner; Cnt increments.
REQ-017 BUSY, R[owner]=1, Cnt == HOLD_MAX, another request pending: grant the next requester per REQ-012 at the same edge, with no idle bubble.
REQ-018 BUSY, R[owner]=1, Cnt == HOLD_MAX, no other request pending: keep the owner; Cnt saturates at HOLD_MAX.
REQ-019 BUSY, R[owner]=0, another request pending: hand over to the next requester at the same edge, with no bubble.
REQ-020 BUSY, R[owner]=0, no request pending: go to IDLE at the next edge.
REQ-021 Handover search SHALL start at P = owner+1, so the old owner is chosen only if it is the sole requester.
REQ-022 En=0 at an edge: go to IDLE; Gn=8'hFF, Valid=0, Wg=0, Cnt=0; P is unchanged.
REQ-023 Output invariant: at most one Gn bit is 0.
REQ-024 Output invariant: Valid=1 implies Gn[Wg]=0.
REQ-025 Output invariant: Valid=0 implies Gn=8'hFF and Wg=0.
REQ-026 Requests arriving or dropping in the same cycle as a handover SHALL be evaluated from the values sampled at that edge only.

Reset
REQ-027 Resetn=0 at an edge SHALL force IDLE, Gn=8'hFF, Wg=0, Valid=0, P=0, Cnt=0, overriding En and R.
REQ-028 Reset asserted mid-grant SHALL drop the grant at that edge, with no partial state retained.
REQ-029 After Resetn returns to 1, the first arbitration SHALL give requester 0 highest priority.

Verification
REQ-030 Reset, then En=1, R=8'h04 -> after 1 edge: Valid=1, Wg=2, Gn[2]=0 with all other bits 1; held while R[2]=1.
REQ-031 R=8'hFF held, HOLD_MAX=4 -> owners 0,0,0,0,1,1,1,1,...,7 (x4), then wrap to 0; never two zeros in Gn.
REQ-032 Owner 5 drops R[5] with R=8'h02 pending -> next edge: Wg=1, Valid stays 1 with no bubble, P=2.
REQ-033 Only R[3]=1, held 10 cycles -> Wg=3 for all 10 cycles, Cnt saturates at 4, no release.
REQ-034 En=0 while owner 6 is granted -> next edge: Gn=8'hFF, Valid=0. With R=8'hC1 and En=1 again -> grant goes to 7 (P=7).
REQ-035 Resetn=0 during a grant with R=8'hFF, En=1 -> next edge: all outputs at reset values. After release -> first grant goes to 0.
